// File: rtl/cdb_request_queue.sv
// Completion buffer between one functional unit and its CDB arbiter leaf.
// Optional same-cycle result bypass to the CDB when built with CDB_BYPASS_EN defined.
module cdb_request_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PTR_W  = 2,
   parameter int unsigned TAG_W  = 6,
   parameter int unsigned DATA_W = 32
) (
   input  logic               clock_IN,
   input  logic               reset_IN,
   input  logic               flush_IN,
   input  logic               result_valid_IN,
   input  logic [TAG_W-1:0]   result_tag_IN,
   input  logic [DATA_W-1:0]  result_data_IN,
   output logic               stall_OUT,
   output logic               request_OUT,
   input  logic               grant_IN,
   output logic               cdb_valid_OUT,
   output logic [TAG_W-1:0]   cdb_tag_OUT,
   output logic [DATA_W-1:0]  cdb_data_OUT,
   output logic [PTR_W:0]     count_OUT,
   output logic               overflow_OUT
);

   localparam int unsigned CNT_W = PTR_W + 1;

   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  head_q;
   logic [PTR_W-1:0]  tail_q;
   logic [CNT_W-1:0]  count_q;
   logic              overflow_q;

   logic full;
   logic empty;
   logic queue_pop;
   logic bypass;
   logic push;
   logic overflow_set;

   // Occupancy-derived status and the push/pop/bypass decisions for this cycle.
   always_comb begin
      full         = (count_q == CNT_W'(DEPTH));
      empty        = (count_q == '0);
      queue_pop    = grant_IN & ~empty;
      overflow_set = result_valid_IN & full & ~flush_IN;
`ifdef CDB_BYPASS_EN
      request_OUT  = ~empty | (result_valid_IN & ~flush_IN);
      bypass       = grant_IN & empty & result_valid_IN & ~flush_IN;
`else
      request_OUT  = ~empty;
      bypass       = 1'b0;
`endif
      push         = result_valid_IN & ~full & ~flush_IN & ~bypass;
   end

   // Broadcast path: head entry on a granted pop, or the live result when bypassing.
   always_comb begin
      cdb_valid_OUT = queue_pop | bypass;
      cdb_tag_OUT   = tag_mem[head_q];
      cdb_data_OUT  = data_mem[head_q];
      if (bypass) begin
         cdb_tag_OUT  = result_tag_IN;
         cdb_data_OUT = result_data_IN;
      end
   end

   always_comb begin
      stall_OUT    = full;
      count_OUT    = count_q;
      overflow_OUT = overflow_q;
   end

   // Pointers and occupancy; flush empties the queue but the granted head still broadcasts.
   always_ff @(posedge clock_IN) begin
      if (!reset_IN) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush_IN) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push)      tail_q <= tail_q + PTR_W'(1);
         if (queue_pop) head_q <= head_q + PTR_W'(1);
         unique case ({push, queue_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Sticky drop indicator; only reset clears it.
   always_ff @(posedge clock_IN) begin
      if (!reset_IN)         overflow_q <= 1'b0;
      else if (overflow_set) overflow_q <= 1'b1;
   end

   // Entry storage carries no reset; contents are only read while occupied.
   always_ff @(posedge clock_IN) begin
      if (reset_IN && push) begin
         tag_mem[tail_q]  <= result_tag_IN;
         data_mem[tail_q] <= result_data_IN;
      end
   end

endmodule

// File: tb/tb_cdb_request_queue.sv
// Directed, self-checking bench for cdb_request_queue with hand-computed expectations.
// Adds the same-cycle bypass scenario when compiled with CDB_BYPASS_EN defined.
module tb_cdb_request_queue;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned PTR_W  = 2;
   localparam int unsigned TAG_W  = 6;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              flush;
   logic              result_valid;
   logic [TAG_W-1:0]  result_tag;
   logic [DATA_W-1:0] result_data;
   logic              stall;
   logic              request;
   logic              grant;
   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;
   logic [PTR_W:0]    count;
   logic              overflow;

   int n_checks = 0;
   int n_errors = 0;

   cdb_request_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
      .clock_IN        (clk),
      .reset_IN        (reset_n),
      .flush_IN        (flush),
      .result_valid_IN (result_valid),
      .result_tag_IN   (result_tag),
      .result_data_IN  (result_data),
      .stall_OUT       (stall),
      .request_OUT     (request),
      .grant_IN        (grant),
      .cdb_valid_OUT   (cdb_valid),
      .cdb_tag_OUT     (cdb_tag),
      .cdb_data_OUT    (cdb_data),
      .count_OUT       (count),
      .overflow_OUT    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle: drive inputs, check same-cycle broadcast, clock, check occupancy.
   task automatic cyc(input string tag, input logic v, input logic [TAG_W-1:0] t,
                      input logic [DATA_W-1:0] d, input logic g, input logic f,
                      input logic ev, input logic [TAG_W-1:0] et,
                      input logic [DATA_W-1:0] ed, input logic [PTR_W:0] ec);
      result_valid = v;
      result_tag   = t;
      result_data  = d;
      grant        = g;
      flush        = f;
      #2;
      check({tag, " cdb_valid"}, 64'(cdb_valid), 64'(ev));
      if (ev) begin
         check({tag, " cdb_tag"},  64'(cdb_tag),  64'(et));
         check({tag, " cdb_data"}, 64'(cdb_data), 64'(ed));
      end
      tick();
      check({tag, " count"}, 64'(count), 64'(ec));
      result_valid = 1'b0;
      grant        = 1'b0;
      flush        = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n      = 1'b0;
      flush        = 1'b0;
      result_valid = 1'b1;
      result_tag   = 6'd63;
      result_data  = 32'hDEAD;
      grant        = 1'b0;

      // Reset held two edges with a result presented.
      tick();
      tick();
      check("rst count", 64'(count), 64'd0);
      check("rst overflow", 64'(overflow), 64'd0);
      check("rst stall", 64'(stall), 64'd0);
      result_valid = 1'b0;
      reset_n = 1'b1;
      #1;
      check("rst request", 64'(request), 64'd0);
      check("rst cdb_valid", 64'(cdb_valid), 64'd0);

      // Streaming: pushes tags 1..3 while grants drain them one cycle behind.
      cyc("s0", 1, 6'd1, 32'hA, 0, 0, 0, 0, 0, 1);
      cyc("s1", 1, 6'd2, 32'hB, 1, 0, 1, 6'd1, 32'hA, 1);
      cyc("s2", 1, 6'd3, 32'hC, 1, 0, 1, 6'd2, 32'hB, 1);
      cyc("s3", 0, 0, 0, 1, 0, 1, 6'd3, 32'hC, 0);
      check("s request low", 64'(request), 64'd0);
      cyc("s idle grant", 0, 0, 0, 1, 0, 0, 0, 0, 0);

      // Fill, overflow on the fifth push, then drain in order.
      cyc("f0", 1, 6'd4, 32'h10, 0, 0, 0, 0, 0, 1);
      cyc("f1", 1, 6'd5, 32'h11, 0, 0, 0, 0, 0, 2);
      cyc("f2", 1, 6'd6, 32'h12, 0, 0, 0, 0, 0, 3);
      check("f stall at 3", 64'(stall), 64'd0);
      cyc("f3", 1, 6'd7, 32'h13, 0, 0, 0, 0, 0, 4);
      check("f stall full", 64'(stall), 64'd1);
      check("f no overflow yet", 64'(overflow), 64'd0);
      cyc("f4 drop", 1, 6'd8, 32'h14, 0, 0, 0, 0, 0, 4);
      check("f overflow", 64'(overflow), 64'd1);
      cyc("d0", 0, 0, 0, 1, 0, 1, 6'd4, 32'h10, 3);
      cyc("d1", 0, 0, 0, 1, 0, 1, 6'd5, 32'h11, 2);
      cyc("d2", 0, 0, 0, 1, 0, 1, 6'd6, 32'h12, 1);
      cyc("d3", 0, 0, 0, 1, 0, 1, 6'd7, 32'h13, 0);
      check("d overflow sticky", 64'(overflow), 64'd1);

      // Full queue under continuous grant; FU only pushes when not stalled. Pointers wrap.
      do_reset();
      check("w overflow cleared", 64'(overflow), 64'd0);
      cyc("w0", 1, 6'd10, 32'h20, 0, 0, 0, 0, 0, 1);
      cyc("w1", 1, 6'd11, 32'h21, 0, 0, 0, 0, 0, 2);
      cyc("w2", 1, 6'd12, 32'h22, 0, 0, 0, 0, 0, 3);
      cyc("w3", 1, 6'd13, 32'h23, 0, 0, 0, 0, 0, 4);
      cyc("wa", 0, 0, 0, 1, 0, 1, 6'd10, 32'h20, 3);
      check("wa stall freed", 64'(stall), 64'd0);
      cyc("wb", 1, 6'd14, 32'h24, 1, 0, 1, 6'd11, 32'h21, 3);
      cyc("wc", 1, 6'd15, 32'h25, 1, 0, 1, 6'd12, 32'h22, 3);
      cyc("wd", 1, 6'd16, 32'h26, 1, 0, 1, 6'd13, 32'h23, 3);
      cyc("we", 1, 6'd17, 32'h27, 1, 0, 1, 6'd14, 32'h24, 3);
      cyc("wf", 1, 6'd18, 32'h28, 1, 0, 1, 6'd15, 32'h25, 3);
      cyc("wg", 0, 0, 0, 1, 0, 1, 6'd16, 32'h26, 2);
      cyc("wh", 0, 0, 0, 1, 0, 1, 6'd17, 32'h27, 1);
      cyc("wi", 0, 0, 0, 1, 0, 1, 6'd18, 32'h28, 0);
      check("w no overflow", 64'(overflow), 64'd0);

      // Flush with a grant: head broadcasts, simultaneous push is discarded.
      cyc("x0", 1, 6'd20, 32'h30, 0, 0, 0, 0, 0, 1);
      cyc("x1", 1, 6'd21, 32'h31, 0, 0, 0, 0, 0, 2);
      cyc("x2", 1, 6'd22, 32'h32, 0, 0, 0, 0, 0, 3);
      cyc("x flush", 1, 6'd23, 32'h33, 1, 1, 1, 6'd20, 32'h30, 0);
      check("x request", 64'(request), 64'd0);
      cyc("x after", 0, 0, 0, 1, 0, 0, 0, 0, 0);
      // Queue restarts cleanly from the flushed pointers.
      cyc("x2 push", 1, 6'd24, 32'h34, 0, 0, 0, 0, 0, 1);
      cyc("x2 pop", 0, 0, 0, 1, 0, 1, 6'd24, 32'h34, 0);

`ifdef CDB_BYPASS_EN
      // Empty queue: granted result goes straight to the CDB; ungranted one is enqueued.
      cyc("b grant", 1, 6'd9, 32'h99, 1, 0, 1, 6'd9, 32'h99, 0);
      cyc("b nogrant", 1, 6'd9, 32'h98, 0, 0, 0, 0, 0, 1);
      // Non-empty: head wins, incoming result queues behind it.
      cyc("b head wins", 1, 6'd40, 32'h40, 1, 0, 1, 6'd9, 32'h98, 1);
      cyc("b drain", 0, 0, 0, 1, 0, 1, 6'd40, 32'h40, 0);
`endif

      // Synchronous reset in the middle of traffic overrides push and pop.
      cyc("r0", 1, 6'd30, 32'h50, 0, 0, 0, 0, 0, 1);
      cyc("r1", 1, 6'd31, 32'h51, 0, 0, 0, 0, 0, 2);
      reset_n      = 1'b0;
      result_valid = 1'b1;
      grant        = 1'b1;
      tick();
      check("r count", 64'(count), 64'd0);
      result_valid = 1'b0;
      grant        = 1'b0;
      reset_n      = 1'b1;
      #1;
      check("r request", 64'(request), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
